// File: rtl/reaction_timer_ctrl.sv
// Reaction timer controller: random wait, GO lamp, ms reaction count.
// Ports: clk, reset(n), tick_1ms, start, btn -> div_clr, led_go, busy,
//   result_ms, result_valid, foul, timeout, state.
module reaction_timer_ctrl #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_EN      = 1,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1ms,
  input  logic        start,
  input  logic        btn,
  output logic        div_clr,
  output logic        led_go,
  output logic        busy,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        foul,
  output logic        timeout,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_FOUL  = 3'd4
  } st_t;

  localparam logic [15:0] MIN_C = 16'(MIN_DELAY_MS);
  localparam logic [13:0] MAX_C = 14'(MAX_MS);
  localparam logic [15:0] SEED  = 16'hACE1;

  st_t         st_q;
  st_t         st_d;
  logic        btn_q;
  logic        btn_rise;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nx;
  logic [15:0] delay_cnt;
  logic [15:0] dly_load;
  logic [13:0] ms_cnt;

  logic launch;
  logic dly_dec;
  logic to_go;
  logic ms_inc;
  logic hit;
  logic ms_max;

  assign btn_rise = btn & ~btn_q;

  // Fibonacci taps 16,14,13,11 (1-based)
  assign lfsr_nx = {lfsr[14:0],
                    lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  assign dly_load = (RAND_EN != 0)
                  ? MIN_C + {5'd0, lfsr[10:0]}
                  : MIN_C;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= S_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    launch  = 1'b0;
    dly_dec = 1'b0;
    to_go   = 1'b0;
    ms_inc  = 1'b0;
    hit     = 1'b0;
    ms_max  = 1'b0;
    unique case (st_q)
      S_IDLE, S_DONE, S_FOUL: begin
        if (start) begin
          st_d   = S_DELAY;
          launch = 1'b1;
        end
      end
      S_DELAY: begin
        // early press beats a coincident tick
        if (btn_rise) begin
          st_d = S_FOUL;
        end else if (tick_1ms) begin
          if (delay_cnt <= 16'd1) begin
            st_d  = S_GO;
            to_go = 1'b1;
          end else begin
            dly_dec = 1'b1;
          end
        end
      end
      S_GO: begin
        // press wins; result is the pre-tick count
        if (btn_rise) begin
          st_d = S_DONE;
          hit  = 1'b1;
        end else if (tick_1ms) begin
          if (ms_cnt == MAX_C) begin
            st_d   = S_DONE;
            ms_max = 1'b1;
          end else begin
            ms_inc = 1'b1;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q     <= 1'b0;
      lfsr      <= SEED;
      delay_cnt <= 16'd0;
      ms_cnt    <= 14'd0;
      result_ms <= 14'd0;
      timeout   <= 1'b0;
    end else begin
      btn_q <= btn;
      lfsr  <= lfsr_nx;
      unique case (1'b1)
        launch: begin
          delay_cnt <= dly_load;
          ms_cnt    <= 14'd0;
          result_ms <= 14'd0;
          timeout   <= 1'b0;
        end
        dly_dec: begin
          delay_cnt <= delay_cnt - 16'd1;
        end
        to_go: begin
          delay_cnt <= 16'd0;
          ms_cnt    <= 14'd0;
        end
        ms_inc: begin
          ms_cnt <= ms_cnt + 14'd1;
        end
        hit: begin
          result_ms <= ms_cnt;
        end
        ms_max: begin
          result_ms <= MAX_C;
          timeout   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    led_go       = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    foul         = 1'b0;
    state        = st_q;
    // only output with a path from inputs; quiet while in reset
    div_clr      = launch & reset;
    unique case (st_q)
      S_DELAY: busy = 1'b1;
      S_GO: begin
        busy   = 1'b1;
        led_go = 1'b1;
      end
      S_DONE:  result_valid = 1'b1;
      S_FOUL:  foul = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: two instances (fixed and random wait)
// checked every cycle against an event-level model plus literal checks.
module tb_reaction_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] st = '0;
  logic [1:0] bt = '0;
  logic [1:0] tk = '0;

  logic [1:0] dclr, lg, bz, rv, fl, to;
  logic [13:0] rm [2];
  logic [2:0]  sv [2];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reaction_timer_ctrl #(
    .MIN_DELAY_MS(5), .RAND_EN(0), .MAX_MS(40)
  ) u0 (
    .clk(clk), .reset(rst_n), .tick_1ms(tk[0]), .start(st[0]),
    .btn(bt[0]), .div_clr(dclr[0]), .led_go(lg[0]), .busy(bz[0]),
    .result_ms(rm[0]), .result_valid(rv[0]), .foul(fl[0]),
    .timeout(to[0]), .state(sv[0])
  );

  reaction_timer_ctrl #(
    .MIN_DELAY_MS(1000), .RAND_EN(1), .MAX_MS(20)
  ) u1 (
    .clk(clk), .reset(rst_n), .tick_1ms(tk[1]), .start(st[1]),
    .btn(bt[1]), .div_clr(dclr[1]), .led_go(lg[1]), .busy(bz[1]),
    .result_ms(rm[1]), .result_valid(rv[1]), .foul(fl[1]),
    .timeout(to[1]), .state(sv[1])
  );

  // model: elapsed ticks since start vs. loaded wait gives ms in GO
  int minv [2] = '{5, 1000};
  int randv [2] = '{0, 1};
  int maxv [2] = '{40, 20};
  int mst [2] = '{0, 0};
  int need [2] = '{0, 0};
  int ticks [2] = '{0, 0};
  int res [2] = '{0, 0};
  int mto [2] = '{0, 0};
  logic bprev [2];
  logic [15:0] ml [2];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic model_step(input int k);
    int ms;
    logic rise;
    rise = bt[k] & ~bprev[k];
    ms = ticks[k] - need[k];
    case (mst[k])
      0, 3, 4: if (st[k]) begin
        need[k] = (randv[k] != 0) ? minv[k] + int'(ml[k][10:0])
                                  : minv[k];
        ticks[k] = 0;
        res[k] = 0;
        mto[k] = 0;
        mst[k] = 1;
      end
      1: if (rise) mst[k] = 4;
         else if (tk[k]) begin
           ticks[k]++;
           if (ticks[k] == need[k]) mst[k] = 2;
         end
      2: if (rise) begin
           res[k] = ms;
           mst[k] = 3;
         end else if (tk[k]) begin
           if (ms == maxv[k]) begin
             res[k] = maxv[k];
             mto[k] = 1;
             mst[k] = 3;
           end else ticks[k]++;
         end
      default: ;
    endcase
    bprev[k] = bt[k];
    ml[k] = lfsr_step(ml[k]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mst[k] = 0; need[k] = 0; ticks[k] = 0;
        res[k] = 0; mto[k] = 0; bprev[k] = 1'b0;
        ml[k] = 16'hACE1;
      end else begin
        model_step(k);
      end
    end
  end

  task automatic chk(input string n, input int k,
                     input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s inst%0d got %0d expected %0d t=%0t",
               n, k, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("state", k, int'(sv[k]), mst[k]);
      chk("led_go", k, int'(lg[k]), int'(mst[k] == 2));
      chk("busy", k, int'(bz[k]), int'(mst[k] == 1 || mst[k] == 2));
      chk("result_valid", k, int'(rv[k]), int'(mst[k] == 3));
      chk("foul", k, int'(fl[k]), int'(mst[k] == 4));
      chk("timeout", k, int'(to[k]), mto[k]);
      chk("result_ms", k, int'(rm[k]), res[k]);
      chk("div_clr", k, int'(dclr[k]),
          int'(rst_n && st[k] && (mst[k] == 0 || mst[k] >= 3)));
    end
  end

  task automatic step(input int k, input logic s,
                      input logic b, input logic t);
    st[k] = s;
    bt[k] = b;
    tk[k] = t;
    @(posedge clk);
    #1;
    st[k] = 1'b0;
    tk[k] = 1'b0;
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 0, int'(sv[0]), 0);
    chk("rst_busy", 1, int'(bz[1]), 0);
    chk("rst_lfsr_seed", 1, int'(u1.lfsr), 16'hACE1);
    st[0] = 1'b1;
    #1 chk("rst_divclr", 0, int'(dclr[0]), 0);
    st[0] = 1'b0;
    rst_n = 1'b1;
    repeat (2) step(0, 0, 0, 1);
    chk("idle_tick", 0, int'(sv[0]), 0);

    // normal run
    st[0] = 1'b1;
    #1 chk("divclr_pulse", 0, int'(dclr[0]), 1);
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("delay_state", 0, int'(sv[0]), 1);
    repeat (4) step(0, 0, 0, 1);
    chk("pre_go", 0, int'(lg[0]), 0);
    step(0, 0, 0, 1);
    chk("go_on_5th", 0, int'(lg[0]), 1);
    repeat (37) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("done_state", 0, int'(sv[0]), 3);
    chk("result_37", 0, int'(rm[0]), 37);
    chk("valid", 0, int'(rv[0]), 1);
    chk("no_timeout", 0, int'(to[0]), 0);
    repeat (3) step(0, 0, 0, 1);
    chk("done_hold", 0, int'(rm[0]), 37);

    // foul
    step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("foul_state", 0, int'(sv[0]), 4);
    chk("foul_flag", 0, int'(fl[0]), 1);
    chk("foul_no_go", 0, int'(lg[0]), 0);
    repeat (2) step(0, 0, 1, 1);
    chk("foul_hold", 0, int'(sv[0]), 4);

    // held button, ignored start, coincident press+tick
    step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 1);
    st[0] = 1'b1;
    #1 chk("busy_start_noclr", 0, int'(dclr[0]), 0);
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("busy_start_ign", 0, int'(sv[0]), 1);
    repeat (3) step(0, 0, 1, 1);
    chk("go_no_reload", 0, int'(lg[0]), 1);
    repeat (3) step(0, 0, 1, 1);
    chk("held_btn_ign", 0, int'(sv[0]), 2);
    step(0, 0, 0, 0);
    repeat (9) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("coinc_state", 0, int'(sv[0]), 3);
    chk("coinc_result", 0, int'(rm[0]), 12);

    // restart from DONE
    st[0] = 1'b1;
    #1 chk("restart_divclr", 0, int'(dclr[0]), 1);
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("restart_state", 0, int'(sv[0]), 1);
    chk("restart_res", 0, int'(rm[0]), 0);
    chk("restart_valid", 0, int'(rv[0]), 0);
    repeat (2) step(0, 0, 0, 1);

    // async reset mid-DELAY
    rst_n = 1'b0;
    #1;
    chk("async_state", 0, int'(sv[0]), 0);
    chk("async_busy", 0, int'(bz[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) step(0, 0, 0, 1);
    chk("post_rst_idle", 0, int'(sv[0]), 0);

    // random wait + timeout
    step(1, 1, 0, 0);
    n = 0;
    do begin
      step(1, 0, 0, 1);
      n++;
    end while (!lg[1] && n < 4000);
    chk("rand_go_reached", 1, int'(lg[1]), 1);
    chk("rand_in_range", 1, int'(n >= 1000 && n <= 3047), 1);
    repeat (20) step(1, 0, 0, 1);
    chk("go_at_max", 1, int'(sv[1]), 2);
    step(1, 0, 0, 1);
    chk("to_state", 1, int'(sv[1]), 3);
    chk("to_result", 1, int'(rm[1]), 20);
    chk("to_flag", 1, int'(to[1]), 1);
    step(1, 0, 1, 1);
    chk("to_hold", 1, int'(rm[1]), 20);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
